// File: rtl/systolic_array_drain_if.sv
// Column-result / aligned-vector stream bundle for systolic_array_drain.
// master drives column results and out_rdy; slave is the drain block.
interface systolic_array_drain_if #(
    parameter int unsigned data_width = 32,
    parameter int unsigned num_cols   = 4
);
    logic [num_cols-1:0]            col_val;
    logic [num_cols*data_width-1:0] col_data;
    logic                           out_val;
    logic                           out_rdy;
    logic [num_cols*data_width-1:0] out_msg;
    logic                           ovf;
    logic [15:0]                    drop_count;

    modport master (
        output col_val, col_data, out_rdy,
        input  out_val, out_msg, ovf, drop_count
    );

    modport slave (
        input  col_val, col_data, out_rdy,
        output out_val, out_msg, ovf, drop_count
    );
endinterface

// File: rtl/systolic_array_drain.sv
// Per-column FIFOs that re-align skewed systolic column results into row vectors.
// Optional drop accounting (ovf, drop_count) is built when SYSTOLIC_DRAIN_OVF_EN is defined.
module systolic_array_drain #(
    parameter int unsigned data_width = 32,
    parameter int unsigned num_cols   = 4,
    parameter int unsigned depth      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    systolic_array_drain_if.slave  bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

    logic [data_width-1:0] mem_q    [num_cols][depth];
    logic [ptr_w-1:0]      wr_ptr_q [num_cols];
    logic [ptr_w-1:0]      rd_ptr_q [num_cols];
    logic [cnt_w-1:0]      cnt_q    [num_cols];

    logic [num_cols-1:0] not_empty;
    logic [num_cols-1:0] full;
    logic [num_cols-1:0] push;
    logic                pop;

    always_comb begin
        not_empty = '0;
        full      = '0;
        for (int c = 0; c < num_cols; c++) begin
            not_empty[c] = (cnt_q[c] != '0);
            full[c]      = (cnt_q[c] == full_cnt);
        end
    end

    assign bus.out_val = &not_empty;
    assign pop         = bus.out_val & bus.out_rdy & ~flush;
    // A full column may still accept a write when the whole vector pops this cycle.
    assign push = bus.col_val & (~full | {num_cols{pop}}) & {num_cols{~flush}};

    always_comb begin
        bus.out_msg = '0;
        for (int c = 0; c < num_cols; c++) begin
            bus.out_msg[c*data_width +: data_width] = mem_q[c][rd_ptr_q[c]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < num_cols; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                for (int e = 0; e < depth; e++) begin
                    mem_q[c][e] <= '0;
                end
            end
        end else if (flush) begin
            for (int c = 0; c < num_cols; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < num_cols; c++) begin
                if (push[c]) begin
                    mem_q[c][wr_ptr_q[c]] <= bus.col_data[c*data_width +: data_width];
                    wr_ptr_q[c]           <= wr_ptr_q[c] + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                end
                if (push[c] && !pop) begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end else if (!push[c] && pop) begin
                    cnt_q[c] <= cnt_q[c] - 1'b1;
                end
            end
        end
    end

`ifdef SYSTOLIC_DRAIN_OVF_EN
    logic [num_cols-1:0] drop;
    logic                ovf_q;
    logic [15:0]         drop_cnt_q;
    logic [16:0]         drop_sum;

    assign drop = bus.col_val & full & {num_cols{~pop & ~flush}};

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int c = 0; c < num_cols; c++) begin
            drop_sum = drop_sum + 17'(drop[c]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (flush) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_q | (|drop);
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign bus.ovf        = ovf_q;
    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.ovf        = 1'b0;
    assign bus.drop_count = '0;
`endif
endmodule

// File: tb/tb_systolic_array_drain.sv
// Self-checking bench for systolic_array_drain: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_systolic_array_drain;
    localparam int DW    = 32;
    localparam int NC    = 4;
    localparam int DEPTH = 4;
`ifdef SYSTOLIC_DRAIN_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;

    systolic_array_drain_if #(.data_width(DW), .num_cols(NC)) bus ();

    systolic_array_drain #(
        .data_width(DW),
        .num_cols  (NC),
        .depth     (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per column, vector pops when every queue is non-empty.
    logic [DW-1:0] mq [NC][$];
    bit            m_ovf;
    int            m_drops;

    function automatic bit m_val();
        bit v = 1'b1;
        for (int c = 0; c < NC; c++) if (mq[c].size() == 0) v = 1'b0;
        return v;
    endfunction

    function automatic logic [NC*DW-1:0] m_head();
        logic [NC*DW-1:0] h = '0;
        for (int c = 0; c < NC; c++) if (mq[c].size() > 0) h[c*DW +: DW] = mq[c][0];
        return h;
    endfunction

    function automatic bit exp_ovf();
        return OvfEn ? m_ovf : 1'b0;
    endfunction

    function automatic logic [15:0] exp_dc();
        return OvfEn ? 16'(m_drops) : 16'h0;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_step();
        bit pop;
        bit was_full [NC];
        if (flush) begin
            model_clear();
            return;
        end
        pop = m_val() && bus.out_rdy;
        for (int c = 0; c < NC; c++) was_full[c] = (mq[c].size() == DEPTH);
        if (pop) for (int c = 0; c < NC; c++) void'(mq[c].pop_front());
        for (int c = 0; c < NC; c++) begin
            if (bus.col_val[c]) begin
                if (!was_full[c] || pop) begin
                    mq[c].push_back(bus.col_data[c*DW +: DW]);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.col_val  = '0;
        bus.col_data = '0;
        bus.out_rdy  = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_flush();
        set_idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        logic [NC*DW-1:0] v;
        set_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL reset_out_val got=%b exp=0", bus.out_val); end
        tests++; if (bus.out_msg !== '0) begin fails++; $display("FAIL reset_out_msg got=%h exp=0", bus.out_msg); end
        tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        tests++; if (bus.drop_count !== 16'h0) begin fails++; $display("FAIL reset_drop_count got=%h exp=0", bus.drop_count); end
        reset = 1'b1;
        model_clear();
        // First write right after release must land on the next edge.
        for (int c = 0; c < NC; c++) v[c*DW +: DW] = $urandom;
        bus.col_val  = '1;
        bus.col_data = v;
        tick();
        tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== v) begin
            fails++; $display("FAIL reset_first_write val=%b msg=%h exp_msg=%h", bus.out_val, bus.out_msg, v);
        end
    endtask

    task automatic test_skew();
        logic [NC*DW-1:0] exp_msg;
        exp_msg = {32'h40, 32'h30, 32'h20, 32'h10};
        do_flush();
        bus.out_rdy = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            bus.col_val  = '0;
            bus.col_data = '0;
            if (k % 2 == 0 && k <= 6) begin
                bus.col_val[k/2]                = 1'b1;
                bus.col_data[(k/2)*DW +: DW]    = 32'(16 * (k/2 + 1));
            end
            tick();
            tests++; if (bus.out_val !== (k == 6)) begin
                fails++; $display("FAIL skew_out_val cycle=%0d got=%b exp=%b", k + 1, bus.out_val, (k == 6));
            end
            if (k == 6) begin
                tests++; if (bus.out_msg !== exp_msg) begin
                    fails++; $display("FAIL skew_out_msg got=%h exp=%h", bus.out_msg, exp_msg);
                end
            end
        end
        set_idle();
    endtask

    task automatic test_backpressure();
        logic [NC*DW-1:0] vec [4];
        do_flush();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NC; c++) vec[i][c*DW +: DW] = $urandom;
            bus.col_val  = '1;
            bus.col_data = vec[i];
            tick();
            tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== vec[0]) begin
                fails++; $display("FAIL bp_hold i=%0d val=%b msg=%h exp=%h", i, bus.out_val, bus.out_msg, vec[0]);
            end
        end
        bus.col_val = '0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== vec[i]) begin
                fails++; $display("FAIL bp_drain i=%0d val=%b msg=%h exp=%h", i, bus.out_val, bus.out_msg, vec[i]);
            end
            tick();
        end
        tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL bp_empty got=%b exp=0", bus.out_val); end
        set_idle();
    endtask

    task automatic test_overflow();
        logic [DW-1:0] w [6];
        do_flush();
        for (int i = 0; i < 6; i++) begin
            w[i]         = $urandom;
            bus.col_val  = 4'b0001;
            bus.col_data = '0;
            bus.col_data[DW-1:0] = w[i];
            tick();
        end
        tests++; if (bus.ovf !== OvfEn) begin fails++; $display("FAIL ovf_flag got=%b exp=%b", bus.ovf, OvfEn); end
        tests++; if (bus.drop_count !== (OvfEn ? 16'd2 : 16'd0)) begin
            fails++; $display("FAIL ovf_drop_count got=%0d exp=%0d", bus.drop_count, OvfEn ? 2 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            bus.col_val = 4'b1110;
            for (int c = 0; c < NC; c++) bus.col_data[c*DW +: DW] = $urandom;
            tick();
        end
        bus.col_val = '0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (bus.out_val !== 1'b1 || bus.out_msg[DW-1:0] !== w[i]) begin
                fails++; $display("FAIL ovf_contents i=%0d val=%b col0=%h exp=%h", i, bus.out_val, bus.out_msg[DW-1:0], w[i]);
            end
            tick();
        end
        tests++; if (bus.drop_count !== (OvfEn ? 16'd2 : 16'd0) || bus.out_val !== 1'b0) begin
            fails++; $display("FAIL ovf_after_drain dc=%0d val=%b", bus.drop_count, bus.out_val);
        end
        set_idle();
    endtask

    task automatic test_full_pop();
        logic [NC*DW-1:0] vec [4];
        logic [NC*DW-1:0] aa;
        aa = {NC{32'hAA}};
        do_flush();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < NC; c++) vec[i][c*DW +: DW] = $urandom;
            bus.col_val  = '1;
            bus.col_data = vec[i];
            tick();
        end
        bus.out_rdy  = 1'b1;
        bus.col_val  = '1;
        bus.col_data = aa;
        tick();
        tests++; if (bus.drop_count !== 16'h0 || bus.ovf !== 1'b0) begin
            fails++; $display("FAIL fullpop_no_drop dc=%0d ovf=%b exp 0/0", bus.drop_count, bus.ovf);
        end
        bus.col_val = '0;
        for (int i = 1; i < 4; i++) begin
            tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== vec[i]) begin
                fails++; $display("FAIL fullpop_drain i=%0d msg=%h exp=%h", i, bus.out_msg, vec[i]);
            end
            tick();
        end
        tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== aa) begin
            fails++; $display("FAIL fullpop_aa val=%b msg=%h exp=%h", bus.out_val, bus.out_msg, aa);
        end
        tick();
        tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL fullpop_empty got=%b exp=0", bus.out_val); end
        set_idle();
    endtask

    task automatic test_flush_reset();
        do_flush();
        for (int i = 0; i < 6; i++) begin
            bus.col_val  = 4'b0011;
            bus.col_data = {4{$urandom}};
            tick();
        end
        set_idle();
        flush = 1'b1;
        bus.col_val = '1;
        bus.out_rdy = 1'b1;
        tick();
        set_idle();
        tests++; if (bus.out_val !== 1'b0 || bus.drop_count !== 16'h0 || bus.ovf !== 1'b0) begin
            fails++; $display("FAIL flush_clear val=%b dc=%0d ovf=%b exp 0/0/0", bus.out_val, bus.drop_count, bus.ovf);
        end
        bus.col_val  = '1;
        bus.col_data = {4{$urandom}};
        tick();
        bus.col_val = '0;
        tests++; if (bus.out_val !== 1'b1) begin fails++; $display("FAIL flush_refill got=%b exp=1", bus.out_val); end
        #2;
        reset = 1'b0;
        #1;
        tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL async_reset got=%b exp=0", bus.out_val); end
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tests++; if (bus.out_val !== 1'b0 || bus.out_msg !== '0) begin
            fails++; $display("FAIL reset_cleared val=%b msg=%h", bus.out_val, bus.out_msg);
        end
    endtask

    task automatic test_random();
        do_flush();
        for (int n = 0; n < 500; n++) begin
            bus.col_val = 4'($urandom);
            for (int c = 0; c < NC; c++) bus.col_data[c*DW +: DW] = $urandom;
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 59) == 0);
            tick();
            tests++; if (bus.out_val !== m_val()) begin
                fails++; $display("FAIL rand_out_val n=%0d got=%b exp=%b", n, bus.out_val, m_val());
            end
            if (m_val()) begin
                tests++; if (bus.out_msg !== m_head()) begin
                    fails++; $display("FAIL rand_out_msg n=%0d got=%h exp=%h", n, bus.out_msg, m_head());
                end
            end
            tests++; if (bus.ovf !== exp_ovf() || bus.drop_count !== exp_dc()) begin
                fails++; $display("FAIL rand_drop n=%0d ovf=%b/%b dc=%0d/%0d", n, bus.ovf, exp_ovf(),
                                  bus.drop_count, exp_dc());
            end
        end
        set_idle();
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        model_clear();
        test_reset();
        test_skew();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_flush_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/systolic_array_drain.md
# systolic_array_drain

Output-side collector for the systolic array. Each column's bottom PE emits its accumulated `y` result, and adjacent columns are skewed in time because `x` passes through the PE pipeline registers. This block captures each column's results into a per-column FIFO, re-aligns them, and presents each completed row vector on a single val/rdy output stream. It sits between the bottom edge of the array and the downstream flow-solver stage, and absorbs downstream backpressure that the free-running array cannot honour.

## Interface
- `data_width`, 32, width of one column result (matches PE `y` width).
- `num_cols`, 4, number of array columns collected (≥1).
- `depth`, 4, entries per column FIFO; power of two, ≥2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0); clears all state immediately.
- `flush`  input  1  synchronous clear of all FIFOs and counters; overrides every other action that cycle.
- `col_val`  input  num_cols  bit c is high when column c presents a result this cycle.
- `col_data`  input  num_cols*data_width  column c result in bits [c*data_width +: data_width].
- `out_val`  output  1  a complete aligned row vector is available.
- `out_rdy`  input  1  downstream accepts the vector.
- `out_msg`  output  num_cols*data_width  column c result in bits [c*data_width +: data_width].
- `ovf`  output  1  sticky flag: at least one column result was dropped (see Configuration).
- `drop_count`  output  16  number of dropped column results, saturating (see Configuration).

## Operation
- One FIFO per column: storage of `depth` x `data_width`, plus write pointer, read pointer, and occupancy counter of width clog2(depth)+1.
- Write, column c: when `col_val[c]` is high and the FIFO is not full, or is full but a pop happens this cycle, `col_data` slice c is written at the write pointer, and the pointer increments with wrap to 0 after `depth`-1.
- Full-FIFO write with no pop: the result is dropped, FIFO contents are unchanged, and the drop is recorded when the macro is enabled.
- `out_val` = every column FIFO has occupancy ≥1. `out_msg` = the head entry of each FIFO.
- Pop: when `out_val && out_rdy`, all FIFOs pop together. Every read pointer increments with wrap, and occupancies decrement.
- Simultaneous push and pop on one column: occupancy is unchanged and both pointers advance.
- Empty FIFO with `col_val` and no vector complete: a normal write.
- Columns are independent on the write side. A column running ahead is held until the lagging columns arrive, bounded by `depth`.
- `flush`: all pointers and occupancies are set to 0. `ovf` and `drop_count` are cleared. Writes and pops that cycle are ignored.
- Arithmetic: pointers are modulo `depth`. The occupancy never exceeds `depth` and never underflows. `drop_count` saturates at 16'hFFFF.

## Timing
- Reset values: `out_val`=0, `out_msg`=0 (storage cleared), `ovf`=0, `drop_count`=0. All pointers and occupancies are 0.
- `out_val` and `out_msg` come only from registered FIFO state. There is no combinational path from `col_val` or `col_data` to any output.
- Latency: the vector is valid in the cycle after the edge that wrote its last-arriving column.
- `out_rdy` may combinationally affect only write acceptance on full FIFOs, never `out_val`.
- `out_val` stays high and `out_msg` stays stable until the handshake completes.
- Asserting `reset` mid-operation discards all held data immediately. After `reset` deasserts, the first `col_val` write is accepted on the next rising edge.
- Throughput: one vector per cycle when the columns are aligned and `out_rdy` is held high.

## Configuration
- `SYSTOLIC_DRAIN_OVF_EN` defined:
  - `ovf` is set in the cycle after the first dropped write and holds until `flush` or `reset`.
  - `drop_count` increments by the number of columns dropped in each cycle.
- `SYSTOLIC_DRAIN_OVF_EN` undefined:
  - Drops still occur as specified under Operation.
  - `ovf` and `drop_count` are tied to 0, and no counter logic is built.

## Test plan
- Skewed arrival, num_cols=4, skew 2: columns 0..3 write 0x10, 0x20, 0x30, 0x40 at cycles 0, 2, 4, 6, with `out_rdy`=1 → `out_val` rises at cycle 7 with `out_msg`={0x40,0x30,0x20,0x10}, and falls at cycle 8.
- Backpressure: `out_rdy`=0 while 4 aligned vectors arrive → `out_val` stays high on vector 0. Then `out_rdy`=1 → vectors 0..3 drain in order, one per cycle.
- Overflow, macro on: `out_rdy`=0, and column 0 is written 6 times with no other columns → the 5th and 6th writes are dropped, `ovf`=1, `drop_count`=2, and the FIFO holds writes 1..4.
- Full with concurrent pop: all FIFOs full, `out_rdy`=1, and all `col_val` high with 0xAA → the head pops, 0xAA is accepted, occupancy stays 4, and no drop occurs.
- Flush and reset: with partial data held, pulse `flush` → the next cycle has `out_val`=0 and `drop_count`=0. Assert `reset` low mid-stream → `out_val` goes 0 without waiting for a clock edge.
- Macro off: repeat the overflow scenario → identical FIFO contents, with `ovf` and `drop_count` remaining 0.
